// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the responder state codes used by the
// SRAM slave. Other AHB-Lite slaves can reuse these definitions.
package ahbl_pkg;

    localparam logic [1:0] HT_IDLE    = 2'b00;
    localparam logic [1:0] HT_BUSY    = 2'b01;
    localparam logic [1:0] HT_NONSEQ  = 2'b10;
    localparam logic [1:0] HT_SEQ     = 2'b11;

    localparam logic [2:0] HS_BYTE    = 3'b000;
    localparam logic [2:0] HS_HALF    = 3'b001;
    localparam logic [2:0] HS_WORD    = 3'b010;

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WAIT  = 3'd1;
    localparam logic [2:0] ACC   = 3'd2;
    localparam logic [2:0] RRESP = 3'd3;
    localparam logic [2:0] ERR1  = 3'd4;
    localparam logic [2:0] ERR2  = 3'd5;

    // SEQ is handled exactly like NONSEQ; IDLE and BUSY never start a transfer.
    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HT_NONSEQ) || (htrans == HT_SEQ);
    endfunction

endpackage

// File: rtl/ahbl_lane_decode.sv
// Byte-lane decoder for 32-bit AHB-Lite slaves: turns HSIZE and the two
// low address bits into per-byte enables and an alignment flag.
module ahbl_lane_decode
    import ahbl_pkg::*;
(
    input  logic [2:0] i_size,
    input  logic [1:0] i_addr_lo,
    output logic [3:0] o_lanes,
    output logic       o_misaligned
);

    // Sizes above a word are treated as a full word.
    always_comb begin
        o_lanes      = 4'b1111;
        o_misaligned = 1'b0;
        case (i_size)
            HS_BYTE: begin
                o_lanes = 4'b0001 << i_addr_lo;
            end
            HS_HALF: begin
                o_lanes      = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_addr_lo[0];
            end
            HS_WORD: begin
                o_misaligned = (i_addr_lo != 2'b00);
            end
            default: begin
                o_misaligned = (i_addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous SRAM with one
// cycle of read latency and per-byte write enables. Address-phase
// attributes are registered and the SRAM is accessed in the data phase,
// after WAIT_STATES stall cycles.
// Optional build macro AHBL_SRAM_ERR_EN: out-of-range or misaligned
// transfers receive a two-cycle ERROR response instead of wrapping.
module ahbl_sram_slave
    import ahbl_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [2:0]    r_state;
    logic [3:0]    r_wait_cnt;
    logic [AW-1:0] r_addr;
    logic          r_write;
    logic [3:0]    r_lanes;

    logic [2:0]    w_next_state;
    logic [2:0]    w_entry_state;
    logic [3:0]    w_lanes;
    logic          w_misaligned;
    logic          w_accept;
    logic          w_take;
    logic          w_err;

    ahbl_lane_decode u_lane_decode (
        .i_size       (HSIZE),
        .i_addr_lo    (HADDR[1:0]),
        .o_lanes      (w_lanes),
        .o_misaligned (w_misaligned)
    );

    assign w_accept = HSEL & htrans_active(HTRANS) & HREADY;
    assign w_take   = w_accept & HREADYOUT;

`ifdef AHBL_SRAM_ERR_EN
    assign w_err = ((HADDR >> (AW + 2)) != 32'd0) | w_misaligned;
`else
    logic w_unused;
    assign w_err    = 1'b0;
    assign w_unused = ^{HADDR[31:AW+2], w_misaligned};
`endif

    assign w_entry_state = w_err ? ERR1 : ((WAIT_STATES > 0) ? WAIT : ACC);

    // Next-state selection; new transfers are only taken in states that drive HREADYOUT high.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = w_entry_state;
            end
            WAIT: begin
                if (r_wait_cnt == WS_LAST) w_next_state = ACC;
            end
            ACC: begin
                if (!r_write)      w_next_state = RRESP;
                else if (w_accept) w_next_state = w_entry_state;
                else               w_next_state = IDLE;
            end
            RRESP: begin
                w_next_state = w_accept ? w_entry_state : IDLE;
            end
`ifdef AHBL_SRAM_ERR_EN
            ERR1: begin
                w_next_state = ERR2;
            end
            ERR2: begin
                w_next_state = w_accept ? w_entry_state : IDLE;
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State and wait counter; reset abandons any pending access immediately.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state    <= IDLE;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == WAIT) && (w_next_state == WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end else begin
                r_wait_cnt <= 4'd0;
            end
        end
    end

    // Capture the address-phase attributes of each accepted transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_lanes <= 4'b0000;
        end else if (w_take) begin
            r_addr  <= HADDR[AW+1:2];
            r_write <= HWRITE;
            r_lanes <= w_lanes;
        end
    end

    // Bus response and SRAM strobes decoded from the current state.
    always_comb begin
        HREADYOUT  = 1'b1;
        HRESP      = HRESP_OKAY;
        HRDATA     = 32'd0;
        sram_en    = 1'b0;
        sram_we    = 4'b0000;
        sram_wdata = 32'd0;
        case (r_state)
            WAIT: begin
                HREADYOUT = 1'b0;
            end
            ACC: begin
                sram_en = 1'b1;
                if (r_write) begin
                    sram_we    = r_lanes;
                    sram_wdata = HWDATA;
                end else begin
                    HREADYOUT = 1'b0;
                end
            end
            RRESP: begin
                HRDATA = sram_rdata;
            end
`ifdef AHBL_SRAM_ERR_EN
            ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ERR2: begin
                HRESP = HRESP_ERROR;
            end
`endif
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign sram_addr = r_addr;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Self-checking bench for ahbl_sram_slave: two slaves (0 and 3 wait states)
// share one AHB-Lite bus, each with its own behavioural SRAM macro.
`timescale 1ns/1ps
module tb_ahbl_sram_slave;
    import ahbl_pkg::*;

    localparam int AW          = 10;
    localparam int DEPTH_WORDS = 2 ** AW;
    localparam int DEPTH_BYTES = 4 * DEPTH_WORDS;
`ifdef AHBL_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int             low;
        logic           respLow;
        logic           resp;
        logic [31:0]    rdata;
        int             enCount;
        logic [3:0]     we;
        logic [AW-1:0]  addr;
        logic [31:0]    wdata;
        bit             timedOut;
    } obs_t;

    typedef struct {
        int             d;
        bit             wr;
        logic [31:0]    a;
        logic [2:0]     sz;
        logic [31:0]    wd;
        int             expLow;
        int             expEn;
        logic [3:0]     expWe;
        logic [AW-1:0]  expAddr;
        logic [31:0]    expRd;
        logic           expResp;
        string          name;
    } vec_t;

    logic clk = 1'b0;
    logic rstN;
    logic memClear;
    logic hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    int          dutSel;

    logic hsel0, hsel1, hready;
    logic ready0, ready1, resp0, resp1, en0, en1;
    logic [31:0] rdata0, rdata1, wdata0, wdata1, srd0, srd1;
    logic [3:0]  we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [31:0] mem0 [DEPTH_WORDS];
    logic [31:0] mem1 [DEPTH_WORDS];

    logic selReady, selResp, selEn;
    logic [31:0] selRdata, selWdata;
    logic [3:0]  selWe;
    logic [AW-1:0] selAddr;

    logic [7:0] refMem [2][DEPTH_BYTES];
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    assign hsel0    = hsel & (dutSel == 0);
    assign hsel1    = hsel & (dutSel == 1);
    assign hready   = (dutSel == 0) ? ready0 : ready1;
    assign selReady = (dutSel == 0) ? ready0 : ready1;
    assign selResp  = (dutSel == 0) ? resp0 : resp1;
    assign selEn    = (dutSel == 0) ? en0 : en1;
    assign selRdata = (dutSel == 0) ? rdata0 : rdata1;
    assign selWdata = (dutSel == 0) ? wdata0 : wdata1;
    assign selWe    = (dutSel == 0) ? we0 : we1;
    assign selAddr  = (dutSel == 0) ? addr0 : addr1;

    ahbl_sram_slave #(.AW(AW), .WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESETn(rstN), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ready0), .HRDATA(rdata0), .HRESP(resp0), .sram_en(en0),
        .sram_we(we0), .sram_addr(addr0), .sram_wdata(wdata0), .sram_rdata(srd0)
    );

    ahbl_sram_slave #(.AW(AW), .WAIT_STATES(3)) u_dut1 (
        .HCLK(clk), .HRESETn(rstN), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready),
        .HREADYOUT(ready1), .HRDATA(rdata1), .HRESP(resp1), .sram_en(en1),
        .sram_we(we1), .sram_addr(addr1), .sram_wdata(wdata1), .sram_rdata(srd1)
    );

    // SRAM macro behind slave 0: one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem0[i] <= 32'd0;
            srd0 <= 32'd0;
        end else if (en0) begin
            if (we0 == 4'b0000) srd0 <= mem0[addr0];
            else for (int b = 0; b < 4; b++) if (we0[b]) mem0[addr0][8*b +: 8] <= wdata0[8*b +: 8];
        end
    end

    // SRAM macro behind slave 1.
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem1[i] <= 32'd0;
            srd1 <= 32'd0;
        end else if (en1) begin
            if (we1 == 4'b0000) srd1 <= mem1[addr1];
            else for (int b = 0; b < 4; b++) if (we1[b]) mem1[addr1][8*b +: 8] <= wdata1[8*b +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference rules: which bytes a transfer touches, and whether it errors.
    function automatic bit byteInLane(input logic [31:0] a, input logic [2:0] sz, input int b);
        case (sz)
            HS_BYTE: return b == int'(a[1:0]);
            HS_HALF: return (b / 2) == int'(a[1]);
            default: return 1'b1;
        endcase
    endfunction

    function automatic bit modelErr(input logic [31:0] a, input logic [2:0] sz);
        bit bad;
        bad = (a >= DEPTH_BYTES) || ((sz == HS_HALF) && a[0]) || ((sz >= HS_WORD) && (a[1:0] != 2'b00));
        return ERR_EN && bad;
    endfunction

    function automatic int wordBase(input logic [31:0] a);
        return int'((a % DEPTH_BYTES) & 32'hFFFF_FFFC);
    endfunction

    task automatic modelUpdate(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
        int base;
        base = wordBase(a);
        if (wr && !modelErr(a, sz))
            for (int b = 0; b < 4; b++) if (byteInLane(a, sz, b)) refMem[d][base + b] = wd[8*b +: 8];
    endtask

    task automatic addrPhase(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [1:0] tr);
        dutSel = d; hsel = 1'b1; haddr = a; hsize = sz; hwrite = wr; htrans = tr;
    endtask

    task automatic idleBus();
        hsel = 1'b0; htrans = HT_IDLE; haddr = 32'd0; hsize = HS_BYTE; hwrite = 1'b0;
    endtask

    // Observe one data phase until HREADYOUT is high; ends 1 ns after the completing edge.
    task automatic dataPhase(input logic [31:0] wd, output obs_t o);
        hwdata = wd;
        o = '{low: 0, respLow: 1'b0, resp: 1'b0, rdata: 32'd0, enCount: 0, we: 4'd0,
              addr: '0, wdata: 32'd0, timedOut: 1'b1};
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (selEn) begin
                o.enCount++; o.we = selWe; o.addr = selAddr; o.wdata = selWdata;
            end
            if (selReady) begin
                o.resp = selResp; o.rdata = selRdata; o.timedOut = 1'b0;
                break;
            end
            o.low++;
            o.respLow = o.respLow | selResp;
        end
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd, input logic [1:0] tr, output obs_t o);
        addrPhase(d, wr, a, sz, tr);
        @(posedge clk); #1;
        idleBus();
        dataPhase(wd, o);
    endtask

    // Compare one observed transfer with the reference model, then update the model.
    task automatic compareObs(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                              input logic [31:0] wd, input obs_t o, input string name);
        bit err;
        int ws, base;
        logic [3:0] expWe;
        logic [31:0] expRd;
        err   = modelErr(a, sz);
        ws    = (d == 0) ? 0 : 3;
        base  = wordBase(a);
        expWe = 4'd0;
        expRd = 32'd0;
        for (int b = 0; b < 4; b++) if (!err && wr && byteInLane(a, sz, b)) expWe[b] = 1'b1;
        if (!err && !wr) expRd = {refMem[d][base+3], refMem[d][base+2], refMem[d][base+1], refMem[d][base]};
        checkOutput({name, ".timeout"}, 32'(o.timedOut), 32'd0);
        checkOutput({name, ".lowCycles"}, o.low, err ? 1 : (wr ? ws : ws + 1));
        checkOutput({name, ".respLow"}, 32'(o.respLow), 32'(err));
        checkOutput({name, ".resp"}, 32'(o.resp), 32'(err));
        checkOutput({name, ".rdata"}, o.rdata, expRd);
        checkOutput({name, ".enCount"}, o.enCount, err ? 0 : 1);
        if (!err) begin
            checkOutput({name, ".we"}, 32'(o.we), 32'(expWe));
            checkOutput({name, ".addr"}, 32'(o.addr), 32'(base / 4));
            if (wr) checkOutput({name, ".wdata"}, o.wdata, wd);
        end
        modelUpdate(d, wr, a, sz, wd);
    endtask

    task automatic addVec(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                          input int expLow, input int expEn, input logic [3:0] expWe, input logic [AW-1:0] expAddr,
                          input logic [31:0] expRd, input logic expResp, input string name);
        vec_t v;
        v = '{d: d, wr: wr, a: a, sz: sz, wd: wd, expLow: expLow, expEn: expEn, expWe: expWe,
              expAddr: expAddr, expRd: expRd, expResp: expResp, name: name};
        vecs.push_back(v);
    endtask

    initial begin
        obs_t o, o2;
        int anyLow, anyEn, anyResp;
        int d;
        bit wr, wr2;
        logic [31:0] a, a2, wd, wd2;
        logic [2:0] sz, sz2;

        // Directed vectors against slave 0 (no wait states), memory starting at zero.
        addVec(0, 1, 32'h10, HS_WORD, 32'hDEADBEEF, 0, 1, 4'hF, 10'd4, 32'd0, 1'b0, "wrWord10");
        addVec(0, 0, 32'h10, HS_WORD, 32'd0,       1, 1, 4'h0, 10'd4, 32'hDEADBEEF, 1'b0, "rdWord10");
        addVec(0, 1, 32'h21, HS_BYTE, 32'h00001100, 0, 1, 4'h2, 10'd8, 32'd0, 1'b0, "wrByte21");
        addVec(0, 1, 32'h22, HS_HALF, 32'h22330000, 0, 1, 4'hC, 10'd8, 32'd0, 1'b0, "wrHalf22");
        addVec(0, 0, 32'h20, HS_WORD, 32'd0,       1, 1, 4'h0, 10'd8, 32'h22331100, 1'b0, "rdWord20");
        addVec(0, 0, 32'h13, HS_BYTE, 32'd0,       1, 1, 4'h0, 10'd4, 32'hDEADBEEF, 1'b0, "rdByte13");
        addVec(0, 1, 32'h0,  HS_WORD, 32'hCAFEF00D, 0, 1, 4'hF, 10'd0, 32'd0, 1'b0, "wrWord0");
`ifdef AHBL_SRAM_ERR_EN
        addVec(0, 0, 32'h1000, HS_WORD, 32'd0, 1, 0, 4'h0, 10'd0, 32'd0, 1'b1, "errRange1000");
        addVec(0, 0, 32'h2,    HS_WORD, 32'd0, 1, 0, 4'h0, 10'd0, 32'd0, 1'b1, "errWord2");
        addVec(0, 1, 32'h31,   HS_HALF, 32'hAAAA5555, 1, 0, 4'h0, 10'd0, 32'd0, 1'b1, "errHalf31");
`else
        addVec(0, 0, 32'h1000, HS_WORD, 32'd0, 1, 1, 4'h0, 10'd0, 32'hCAFEF00D, 1'b0, "alias1000");
        addVec(0, 0, 32'h2,    HS_WORD, 32'd0, 1, 1, 4'h0, 10'd0, 32'hCAFEF00D, 1'b0, "misWord2");
        addVec(0, 1, 32'h31,   HS_HALF, 32'hAAAA5555, 0, 1, 4'h3, 10'd12, 32'd0, 1'b0, "misHalf31");
`endif

        for (int i = 0; i < 2; i++) for (int j = 0; j < DEPTH_BYTES; j++) refMem[i][j] = 8'd0;
        rstN = 1'b0; memClear = 1'b1; dutSel = 0; hwdata = 32'd0;
        idleBus();
        repeat (2) @(posedge clk);
        memClear = 1'b0;

        // Reset values.
        @(negedge clk);
        checkOutput("rst.readyout", 32'(ready0), 32'd1);
        checkOutput("rst.resp", 32'(resp0), 32'd0);
        checkOutput("rst.rdata", rdata0, 32'd0);
        checkOutput("rst.sramEn", 32'(en0), 32'd0);
        checkOutput("rst.sramWe", 32'(we0), 32'd0);
        checkOutput("rst.sramAddr", 32'(addr0), 32'd0);
        checkOutput("rst.sramWdata", wdata0, 32'd0);
        checkOutput("rst.readyout1", 32'(ready1), 32'd1);
        rstN = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd, HT_NONSEQ, o);
            checkOutput({vecs[i].name, ".lowCycles"}, o.low, vecs[i].expLow);
            checkOutput({vecs[i].name, ".enCount"}, o.enCount, vecs[i].expEn);
            checkOutput({vecs[i].name, ".we"}, 32'(o.we), 32'(vecs[i].expWe));
            checkOutput({vecs[i].name, ".addr"}, 32'(o.addr), 32'(vecs[i].expAddr));
            checkOutput({vecs[i].name, ".rdata"}, o.rdata, vecs[i].expRd);
            checkOutput({vecs[i].name, ".resp"}, 32'(o.resp), 32'(vecs[i].expResp));
            checkOutput({vecs[i].name, ".respLow"}, 32'(o.respLow), 32'(vecs[i].expResp));
            modelUpdate(vecs[i].d, vecs[i].wr, vecs[i].a, vecs[i].sz, vecs[i].wd);
        end

        // Three wait states: back-to-back write then read of address 0.
        addrPhase(1, 1'b1, 32'h0, HS_WORD, HT_NONSEQ);
        @(posedge clk); #1;
        addrPhase(1, 1'b0, 32'h0, HS_WORD, HT_NONSEQ);
        dataPhase(32'h12345678, o);
        idleBus();
        dataPhase(32'd0, o2);
        compareObs(1, 1'b1, 32'h0, HS_WORD, 32'h12345678, o, "b2bWrite");
        compareObs(1, 1'b0, 32'h0, HS_WORD, 32'd0, o2, "b2bRead");

        // BUSY while selected, then NONSEQ while deselected: no transfer at all.
        for (int pass = 0; pass < 2; pass++) begin
            dutSel = 0; hsel = (pass == 0); htrans = (pass == 0) ? HT_BUSY : HT_NONSEQ;
            haddr = 32'h10; hwrite = 1'b1; hsize = HS_WORD;
            anyLow = 0; anyEn = 0; anyResp = 0;
            repeat (4) begin
                @(negedge clk);
                if (!selReady) anyLow++;
                if (selEn) anyEn++;
                if (selResp) anyResp++;
            end
            checkOutput(pass == 0 ? "busy.lowCycles" : "unsel.lowCycles", anyLow, 0);
            checkOutput(pass == 0 ? "busy.sramEn" : "unsel.sramEn", anyEn, 0);
            checkOutput(pass == 0 ? "busy.resp" : "unsel.resp", anyResp, 0);
            @(posedge clk); #1;
        end
        idleBus();

        // Reset during the wait states of a write drops that write.
        applyStimulus(1, 1'b1, 32'h40, HS_WORD, 32'hA5A5A5A5, HT_NONSEQ, o);
        compareObs(1, 1'b1, 32'h40, HS_WORD, 32'hA5A5A5A5, o, "preRstWrite");
        addrPhase(1, 1'b1, 32'h40, HS_WORD, HT_NONSEQ);
        @(posedge clk); #1;
        idleBus();
        hwdata = 32'h5A5A5A5A;
        @(negedge clk);
        checkOutput("rstWait.inWait", 32'(selReady), 32'd0);
        #1 rstN = 1'b0;
        #2 rstN = 1'b1;
        anyLow = 0; anyEn = 0;
        repeat (6) begin
            @(negedge clk);
            if (!selReady) anyLow++;
            if (selEn) anyEn++;
        end
        checkOutput("rstWait.lowCycles", anyLow, 0);
        checkOutput("rstWait.sramEn", anyEn, 0);
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 32'h40, HS_WORD, 32'd0, HT_NONSEQ, o);
        compareObs(1, 1'b0, 32'h40, HS_WORD, 32'd0, o, "postRstRead");

        // Randomized transfers, sometimes back-to-back, checked against the byte-array model.
        for (int i = 0; i < 80; i++) begin
            d   = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            sz  = 3'($urandom_range(0, 2));
            a   = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h1000;
            wd  = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                wr2 = 1'($urandom_range(0, 1));
                sz2 = 3'($urandom_range(0, 2));
                a2  = 32'($urandom_range(0, 63));
                wd2 = $urandom;
                addrPhase(d, wr, a, sz, HT_NONSEQ);
                @(posedge clk); #1;
                addrPhase(d, wr2, a2, sz2, HT_SEQ);
                dataPhase(wd, o);
                idleBus();
                dataPhase(wd2, o2);
                compareObs(d, wr, a, sz, wd, o, $sformatf("rndPairA%0d", i));
                compareObs(d, wr2, a2, sz2, wd2, o2, $sformatf("rndPairB%0d", i));
            end else begin
                applyStimulus(d, wr, a, sz, wd, ($urandom_range(0, 1) == 0) ? HT_NONSEQ : HT_SEQ, o);
                compareObs(d, wr, a, sz, wd, o, $sformatf("rnd%0d", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
